// File: rtl/semimips_pkg.sv
// rtl/semimips_pkg.sv - shared encodings for the semiMIPS execute stage
// Purpose: ALU op, operand-select and destination-select encodings, R-type
//   funct codes, and the multiply/divide FSM state type.
// Ports: none (package).
package semimips_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_AND   = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_SLT   = 3'b100;
  localparam logic [2:0] ALUOP_FUNCT = 3'b101;

  localparam logic [1:0] ALUSRC_RT   = 2'b00;
  localparam logic [1:0] ALUSRC_SEXT = 2'b01;
  localparam logic [1:0] ALUSRC_ZEXT = 2'b10;
  localparam logic [1:0] ALUSRC_LUI  = 2'b11;

  localparam logic [1:0] REGDST_RT   = 2'b00;
  localparam logic [1:0] REGDST_RD   = 2'b01;
  localparam logic [1:0] REGDST_RA   = 2'b10;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative 32-step signed multiply / restoring divide with HI/LO
// Purpose: accepts an operation when idle, runs 32 iterations, writes HI/LO on
//   the final iteration.
// Ports: clk, rst (async active-high), start (request), isdiv (1 = div),
//   a/b (dividend/multiplicand, divisor/multiplier), busy, hi, lo.
module muldiv
  import semimips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        isdiv,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        isdiv_q, isdiv_d;
  logic        neg_q, neg_d;     // final product/quotient must be negated
  logic        rneg_q, rneg_d;   // remainder takes the dividend's sign
  logic        dz_q, dz_d;       // divide by zero
  logic [31:0] m_q, m_d;         // multiplicand or divisor magnitude
  logic [63:0] p_q, p_d;         // {upper accumulator/remainder, lower multiplier/quotient}
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] a_mag, b_mag;
  logic [63:0] p_sh, p_step, prod_fix;
  logic [32:0] mul_sum, div_diff;

  always_comb begin
    a_mag = a[31] ? -a : a;
    b_mag = b[31] ? -b : b;

    // Multiply: add multiplicand into the upper half when the multiplier LSB
    // is set, then shift the whole pair right (carry enters at the top).
    mul_sum = {1'b0, p_q[63:32]} + {1'b0, (p_q[0] ? m_q : 32'd0)};

    // Divide: shift {rem, dividend} left, trial-subtract, keep on no borrow.
    p_sh     = {p_q[62:0], 1'b0};
    div_diff = {1'b0, p_sh[63:32]} - {1'b0, m_q};

    if (isdiv_q) begin
      p_step = div_diff[32] ? p_sh : {div_diff[31:0], p_sh[31:1], 1'b1};
    end else begin
      p_step = {mul_sum, p_q[31:1]};
    end
    prod_fix = neg_q ? -p_step : p_step;

    state_d = state_q;
    cnt_d   = cnt_q;
    isdiv_d = isdiv_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    m_d     = m_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_RUN;
          cnt_d   = 5'd0;
          isdiv_d = isdiv;
          neg_d   = a[31] ^ b[31];
          rneg_d  = a[31];
          dz_d    = isdiv && (b == 32'd0);
          m_d     = isdiv ? b_mag : a_mag;
          p_d     = {32'd0, (isdiv ? a_mag : b_mag)};
        end
      end
      MD_RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = MD_IDLE;
          cnt_d   = 5'd0;
          if (isdiv_q) begin
            // Divisor 0 leaves rem = |dividend|, so the sign rule restores it.
            hi_d = rneg_q ? -p_step[63:32] : p_step[63:32];
            lo_d = dz_q ? 32'hFFFF_FFFF : prod_fix[31:0];
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= 5'd0;
      isdiv_q <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      m_q     <= 32'd0;
      p_q     <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      isdiv_q <= isdiv_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      m_q     <= m_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == MD_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/exunit.sv
// rtl/exunit.sv - semiMIPS execute stage: operand muxes, ALU, regdst, mul/div stall
// Purpose: combinational ALU result and destination register; hosts the
//   multiply/divide unit and raises stall while it is busy.
// Ports: clk, rst (async active-high), EX controls alualtsrc/alusrc/regdst/aluop,
//   funct, operands rsdata/rtdata/imm/shamt, indices rt/rd;
//   outputs aluresult, zero, wreg, stall, busy.
module exunit
  import semimips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        alualtsrc,
  input  logic [1:0]  alusrc,
  input  logic [1:0]  regdst,
  input  logic [2:0]  aluop,
  input  logic [5:0]  funct,
  input  logic [31:0] rsdata,
  input  logic [31:0] rtdata,
  input  logic [15:0] imm,
  input  logic [4:0]  shamt,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic [31:0] aluresult,
  output logic        zero,
  output logic [4:0]  wreg,
  output logic        stall,
  output logic        busy
);

  logic [31:0] op_a, op_b, hi, lo;
  logic        is_muldiv, is_hilo, md_start;

  always_comb begin
    op_a = alualtsrc ? {27'd0, shamt} : rsdata;
    case (alusrc)
      ALUSRC_RT:   op_b = rtdata;
      ALUSRC_SEXT: op_b = {{16{imm[15]}}, imm};
      ALUSRC_ZEXT: op_b = {16'd0, imm};
      default:     op_b = {imm, 16'd0};
    endcase

    case (regdst)
      REGDST_RD: wreg = rd;
      REGDST_RA: wreg = 5'd31;
      default:   wreg = rt;
    endcase

    is_muldiv = (aluop == ALUOP_FUNCT) && (funct == FUNCT_MULT || funct == FUNCT_DIV);
    is_hilo   = (aluop == ALUOP_FUNCT) && (funct == FUNCT_MFHI || funct == FUNCT_MFLO);
    stall     = (is_muldiv || is_hilo) && busy;
    md_start  = is_muldiv && !busy;

    case (aluop)
      ALUOP_SUB: aluresult = op_a - op_b;
      ALUOP_AND: aluresult = op_a & op_b;
      ALUOP_OR:  aluresult = op_a | op_b;
      ALUOP_SLT: aluresult = {31'd0, $signed(op_a) < $signed(op_b)};
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_SUB:  aluresult = op_a - op_b;
          FUNCT_AND:  aluresult = op_a & op_b;
          FUNCT_OR:   aluresult = op_a | op_b;
          FUNCT_SLT:  aluresult = {31'd0, $signed(op_a) < $signed(op_b)};
          FUNCT_SLL:  aluresult = op_b << op_a[4:0];
          FUNCT_MULT: aluresult = 32'd0;
          FUNCT_DIV:  aluresult = 32'd0;
          FUNCT_MFHI: aluresult = hi;
          FUNCT_MFLO: aluresult = lo;
          default:    aluresult = op_a + op_b;
        endcase
      end
      default: aluresult = op_a + op_b;
    endcase
    zero = (aluresult == 32'd0);
  end

  muldiv u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .isdiv (funct == FUNCT_DIV),
    .a     (op_a),
    .b     (op_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_exunit.sv
// tb/tb_exunit.sv - self-checking bench for exunit against a behavioural model
module tb_exunit;

  logic        clk, rst, alualtsrc;
  logic [1:0]  alusrc, regdst;
  logic [2:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] rsdata, rtdata;
  logic [15:0] imm;
  logic [4:0]  shamt, rt, rd;
  logic [31:0] aluresult;
  logic        zero, stall, busy;
  logic [4:0]  wreg;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  exunit dut (
    .clk(clk), .rst(rst), .alualtsrc(alualtsrc), .alusrc(alusrc), .regdst(regdst),
    .aluop(aluop), .funct(funct), .rsdata(rsdata), .rtdata(rtdata), .imm(imm),
    .shamt(shamt), .rt(rt), .rd(rd), .aluresult(aluresult), .zero(zero),
    .wreg(wreg), .stall(stall), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic alt, input logic [1:0] src,
      input logic [2:0] op, input logic [5:0] fn, input logic [31:0] rs,
      input logic [31:0] rtv, input logic [15:0] im, input logic [4:0] sh,
      input logic [31:0] h, input logic [31:0] l);
    longint x, y, r;
    x = alt ? longint'(sh) : longint'(rs);
    if (src == 2'd0)      y = longint'(rtv);
    else if (src == 2'd1) y = longint'($signed(im)) & 64'hFFFF_FFFF;
    else if (src == 2'd2) y = longint'(im);
    else                  y = longint'(im) * 65536;
    if (op == 3'd5) begin
      if (fn == 6'd32)      r = x + y;
      else if (fn == 6'd34) r = x - y;
      else if (fn == 6'd36) r = x & y;
      else if (fn == 6'd37) r = x | y;
      else if (fn == 6'd42) r = (longint'($signed(32'(x))) < longint'($signed(32'(y)))) ? 1 : 0;
      else if (fn == 6'd0)  r = y * (longint'(1) << (x % 32));
      else if (fn == 6'd24 || fn == 6'd26) r = 0;
      else if (fn == 6'd16) r = longint'(h);
      else if (fn == 6'd18) r = longint'(l);
      else                  r = x + y;
    end
    else if (op == 3'd1) r = x - y;
    else if (op == 3'd2) r = x & y;
    else if (op == 3'd3) r = x | y;
    else if (op == 3'd4) r = (longint'($signed(32'(x))) < longint'($signed(32'(y)))) ? 1 : 0;
    else                 r = x + y;
    return 32'(r);
  endfunction

  function automatic logic [4:0] ref_wreg(input logic [1:0] sel, input logic [4:0] t, input logic [4:0] d);
    if (sel == 2'd1) return d;
    if (sel == 2'd2) return 5'd31;
    return t;
  endfunction

  task automatic ref_md(input logic isdiv, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] h, output logic [31:0] l);
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!isdiv) begin
      p = sx * sy;
      h = p[63:32];
      l = p[31:0];
    end else if (y == 32'd0) begin
      h = x;
      l = 32'hFFFF_FFFF;
    end else begin
      q = sx / sy;
      r = sx % sy;
      h = r[31:0];
      l = q[31:0];
    end
  endtask

  task automatic drive(input logic alt, input logic [1:0] src, input logic [1:0] dst,
      input logic [2:0] op, input logic [5:0] fn, input logic [31:0] rs,
      input logic [31:0] rtv, input logic [15:0] im, input logic [4:0] sh,
      input logic [4:0] t, input logic [4:0] d);
    alualtsrc = alt; alusrc = src; regdst = dst; aluop = op; funct = fn;
    rsdata = rs; rtdata = rtv; imm = im; shamt = sh; rt = t; rd = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 2'd0, 2'd0, 3'd0, 6'd0, 32'd5, 32'd6, 16'd0, 5'd0, 5'd3, 5'd9);
    #3;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    checks++; if (aluresult !== 32'd11) begin failures++; $display("FAIL bubble_result got=%h exp=%h", aluresult, 32'd11); end
    checks++; if (wreg !== 5'd3) begin failures++; $display("FAIL bubble_wreg got=%0d exp=3", wreg); end
    funct = 6'b010000; aluop = 3'd5;
    #1;
    checks++; if (aluresult !== 32'd0 || stall !== 1'b0) begin failures++; $display("FAIL reset_mfhi got=%h stall=%0b exp=0", aluresult, stall); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 3'd0, 6'd0, 32'd0, 32'd0, 16'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_alu_directed;
    logic [31:0] e;
    drive(1'b0, 2'd0, 2'd0, 3'd0, 6'd0, 32'd7, -32'sd3, 16'd0, 5'd0, 5'd1, 5'd2); #1;
    checks++; if (aluresult !== 32'd4 || zero !== 1'b0) begin failures++; $display("FAIL add_7_m3 got=%h z=%0b exp=4 z=0", aluresult, zero); end
    drive(1'b0, 2'd0, 2'd0, 3'd1, 6'd0, 32'd5, 32'd5, 16'd0, 5'd0, 5'd1, 5'd2); #1;
    checks++; if (aluresult !== 32'd0 || zero !== 1'b1) begin failures++; $display("FAIL sub_5_5 got=%h z=%0b exp=0 z=1", aluresult, zero); end
    drive(1'b0, 2'd0, 2'd0, 3'd4, 6'd0, 32'hFFFF_FFFF, 32'd1, 16'd0, 5'd0, 5'd1, 5'd2); #1;
    checks++; if (aluresult !== 32'd1) begin failures++; $display("FAIL slt_m1_1 got=%h exp=1", aluresult); end
    drive(1'b1, 2'd0, 2'd0, 3'd5, 6'b000000, 32'd0, 32'd1, 16'd0, 5'd31, 5'd1, 5'd2); #1;
    e = 32'h8000_0000;
    checks++; if (aluresult !== e) begin failures++; $display("FAIL sll_31 got=%h exp=%h", aluresult, e); end
    drive(1'b0, 2'd3, 2'd0, 3'd0, 6'd0, 32'd0, 32'd0, 16'h1234, 5'd0, 5'd1, 5'd2); #1;
    e = 32'h1234_0000;
    checks++; if (aluresult !== e) begin failures++; $display("FAIL lui_1234 got=%h exp=%h", aluresult, e); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, 2'(i), 3'd0, 6'd0, 32'd0, 32'd0, 16'd0, 5'd0, 5'd5, 5'd9); #1;
      e = (i == 1) ? 32'd9 : (i == 2) ? 32'd31 : 32'd5;
      checks++; if (wreg !== e[4:0]) begin failures++; $display("FAIL regdst_%0d got=%0d exp=%0d", i, wreg, e[4:0]); end
    end
  endtask

  task automatic test_alu_random;
    logic [5:0] fns [9];
    logic [31:0] e;
    logic [4:0] ew;
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd16, 6'd18, 6'd63};
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      drive(1'($urandom), 2'($urandom), 2'($urandom), 3'($urandom), fns[$urandom_range(0, 8)],
            (i % 7 == 0) ? 32'h8000_0000 : $urandom, (i % 5 == 0) ? 32'd0 : $urandom,
            16'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      #1;
      e  = ref_alu(alualtsrc, alusrc, aluop, funct, rsdata, rtdata, imm, shamt, m_hi, m_lo);
      ew = ref_wreg(regdst, rt, rd);
      checks++; if (aluresult !== e) begin failures++; $display("FAIL rand_alu[%0d] op=%0d fn=%0d got=%h exp=%h", i, aluop, funct, aluresult, e); end
      checks++; if (zero !== (e == 32'd0)) begin failures++; $display("FAIL rand_zero[%0d] got=%0b exp=%0b", i, zero, e == 32'd0); end
      checks++; if (wreg !== ew) begin failures++; $display("FAIL rand_wreg[%0d] got=%0d exp=%0d", i, wreg, ew); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rand_stall[%0d] got=%0b exp=0", i, stall); end
    end
  endtask

  // Issue mult/div, then mfhi/mflo on the following cycles; count stall cycles.
  task automatic run_md(input logic isdiv, input logic [31:0] x, input logic [31:0] y, input string nm);
    int n;
    logic [31:0] eh, el;
    ref_md(isdiv, x, y, eh, el);
    @(negedge clk);
    drive(1'b0, 2'd0, 2'd0, 3'd5, isdiv ? 6'b011010 : 6'b011000, x, y, 16'd0, 5'd0, 5'd0, 5'd0);
    #1;
    checks++; if (stall !== 1'b0 || aluresult !== 32'd0) begin failures++; $display("FAIL %s_issue stall=%0b res=%h exp stall=0 res=0", nm, stall, aluresult); end
    @(negedge clk);
    funct = 6'b010000; rsdata = $urandom; rtdata = $urandom;
    n = 0; #1;
    while (stall === 1'b1 && n < 100) begin n++; @(negedge clk); #1; end
    checks++; if (n != 32) begin failures++; $display("FAIL %s_stall_cycles got=%0d exp=32", nm, n); end
    checks++; if (aluresult !== eh) begin failures++; $display("FAIL %s_hi got=%h exp=%h", nm, aluresult, eh); end
    funct = 6'b010010; #1;
    checks++; if (aluresult !== el) begin failures++; $display("FAIL %s_lo got=%h exp=%h", nm, aluresult, el); end
    m_hi = eh; m_lo = el;
  endtask

  task automatic test_mult;
    run_md(1'b0, -32'sd3, 32'd7, "mult_m3x7");
    checks++; if (m_hi !== 32'hFFFF_FFFF || m_lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_m3x7_model got=%h_%h exp=ffffffff_ffffffeb", m_hi, m_lo); end
    for (int i = 0; i < 3; i++) run_md(1'b0, $urandom, $urandom, "mult_rand");
  endtask

  task automatic test_div;
    run_md(1'b1, -32'sd7, 32'd2, "div_m7_2");
    run_md(1'b1, 32'd9, 32'd0, "div_9_0");
    run_md(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    for (int i = 0; i < 3; i++) run_md(1'b1, $urandom, 32'($urandom_range(1, 50000)), "div_rand");
  endtask

  task automatic test_back_to_back;
    int n1, n2;
    logic [31:0] x1, y1, x2, y2, eh1, el1, eh2, el2;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = -32'sd12345;
    ref_md(1'b0, x1, y1, eh1, el1);
    ref_md(1'b0, x2, y2, eh2, el2);
    @(negedge clk);
    drive(1'b0, 2'd0, 2'd0, 3'd5, 6'b011000, x1, y1, 16'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    rsdata = x2; rtdata = y2;
    n1 = 0; #1;
    while (stall === 1'b1 && n1 < 100) begin n1++; @(negedge clk); #1; end
    checks++; if (n1 != 32) begin failures++; $display("FAIL b2b_first_stall got=%0d exp=32", n1); end
    funct = 6'b010000; #1;
    checks++; if (aluresult !== eh1) begin failures++; $display("FAIL b2b_first_hi got=%h exp=%h", aluresult, eh1); end
    funct = 6'b011000;
    @(negedge clk);
    funct = 6'b010000; rsdata = $urandom; rtdata = $urandom;
    n2 = 0; #1;
    while (stall === 1'b1 && n2 < 100) begin n2++; @(negedge clk); #1; end
    checks++; if (n2 != 32) begin failures++; $display("FAIL b2b_second_stall got=%0d exp=32", n2); end
    checks++; if (aluresult !== eh2) begin failures++; $display("FAIL b2b_hi got=%h exp=%h", aluresult, eh2); end
    funct = 6'b010010; #1;
    checks++; if (aluresult !== el2) begin failures++; $display("FAIL b2b_lo got=%h exp=%h", aluresult, el2); end
    m_hi = eh2; m_lo = el2;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive(1'b0, 2'd0, 2'd0, 3'd5, 6'b011000, 32'h1234_5678, 32'h0BAD_CAFE, 16'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    funct = 6'b010000;
    repeat (15) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1 || stall !== 1'b1) begin failures++; $display("FAIL mid_busy busy=%0b stall=%0b exp 1 1", busy, stall); end
    rst = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%0b exp=0", busy); end
    checks++; if (stall !== 1'b0 || aluresult !== 32'd0) begin failures++; $display("FAIL rst_mid_hi stall=%0b got=%h exp=0", stall, aluresult); end
    @(negedge clk);
    rst = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    #1;
    checks++; if (stall !== 1'b0 || aluresult !== 32'd0) begin failures++; $display("FAIL after_rst_mfhi stall=%0b got=%h exp=0", stall, aluresult); end
    funct = 6'b010010; #1;
    checks++; if (aluresult !== 32'd0) begin failures++; $display("FAIL after_rst_mflo got=%h exp=0", aluresult); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL after_rst_busy got=%0b exp=0", busy); end
  endtask

  initial begin
    test_reset;
    test_alu_directed;
    test_alu_random;
    test_mult;
    test_div;
    test_back_to_back;
    test_reset_mid;
    test_alu_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
